// File: rtl/qif_pkg.sv
// Shared constants and types for the QIF neuron datapath: current width, internal sum width,
// clamp limits, weight type and the neuron's reset/peak potentials.
package qif_pkg;

    localparam int I_W   = 8;
    localparam int SUM_W = 10;
    localparam int I_MAX = 127;
    localparam int I_MIN = -128;

    // Membrane potentials used by the downstream neuron stage
    localparam int V_RESET = -64;
    localparam int V_PEAK  = 127;

    typedef logic signed [I_W-1:0]   weight_t;
    typedef logic signed [I_W-1:0]   cur_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    function automatic cur_t clamp_sum(input sum_t s);
        if (s > sum_t'(I_MAX)) return cur_t'(I_MAX);
        if (s < sum_t'(I_MIN)) return cur_t'(I_MIN);
        return cur_t'(s);
    endfunction

    function automatic logic clamp_hit(input sum_t s);
        return (s > sum_t'(I_MAX)) || (s < sum_t'(I_MIN));
    endfunction

endpackage

// File: rtl/qif_evt_fifo.sv
// Small event FIFO holding channel indices; pointers carry a wrap bit so full and
// empty are distinguished, and both flags are registered.
module qif_evt_fifo
    import qif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        // A full FIFO refuses pushes even when a pop frees a slot this cycle
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/qif_synapse.sv
// Synaptic current front-end: buffers weighted spike events, decays the current toward zero
// and adds one event weight per tick. Define QIF_SYN_SATCNT_EN for the sat_cnt port/counter.
module qif_synapse
    import qif_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int DEPTH       = 4,
    parameter int DECAY_SHIFT = 2,
    parameter int W_INIT      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic [$clog2(N_IN)-1:0] ev_ch,
    input  logic                    w_we,
    input  logic [$clog2(N_IN)-1:0] w_addr,
    input  weight_t                 w_data,
    output cur_t                    I_syn
`ifdef QIF_SYN_SATCNT_EN
    ,
    output logic [7:0]              sat_cnt
`endif
);

    localparam int CH_W = $clog2(N_IN);

    logic            fifo_full, fifo_empty, pop_en;
    logic [CH_W-1:0] head_ch;
    weight_t         w_tab [N_IN];
    weight_t         w_sel;
    cur_t            i_syn_q, i_syn_d;
    sum_t            i_ext, d_ext, w_ext, s_sum;
    logic [I_W-1:0]  mag, m;

    // rst_n is active-high despite its name
    qif_evt_fifo #(
        .DEPTH (DEPTH),
        .DW    (CH_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (ev_valid),
        .pop   (pop_en),
        .din   (ev_ch),
        .dout  (head_ch),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop_en   = tick && !fifo_empty;
    assign ev_ready = !fifo_full;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_wt
            weight_t w_q, w_d;
            always_comb begin
                w_d = w_q;
                if (w_we && (w_addr == CH_W'(gi))) w_d = w_data;
            end
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) w_q <= weight_t'(W_INIT);
                else       w_q <= w_d;
            end
            assign w_tab[gi] = w_q;
        end
    endgenerate

    always_comb begin
        // A pop reads the table as it stood before this edge's weight write
        w_sel = pop_en ? w_tab[head_ch] : '0;
        mag   = i_syn_q[I_W-1] ? ((~i_syn_q) + I_W'(1)) : i_syn_q;
        m     = mag >> DECAY_SHIFT;
        if ((m == '0) && (i_syn_q != '0)) m = I_W'(1);
        d_ext = i_syn_q[I_W-1] ? -sum_t'(m) : sum_t'(m);
        i_ext = sum_t'(i_syn_q);
        w_ext = sum_t'(w_sel);
        s_sum = i_ext - d_ext + w_ext;
        i_syn_d = i_syn_q;
        if (tick) i_syn_d = clamp_sum(s_sum);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) i_syn_q <= '0;
        else       i_syn_q <= i_syn_d;
    end

    assign I_syn = i_syn_q;

`ifdef QIF_SYN_SATCNT_EN
    logic [7:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (tick && clamp_hit(s_sum) && (sat_cnt_q != 8'hFF)) sat_cnt_d = sat_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) sat_cnt_q <= '0;
        else       sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_qif_synapse.sv
// Randomized and directed bench for qif_synapse against a queue-based behavioural model.
// Define QIF_SYN_SATCNT_EN to also check the saturation counter.
module tb_qif_synapse;

    localparam int N_IN   = 4;
    localparam int DEPTH  = 4;
    localparam int DSHIFT = 2;
    localparam int W_INIT = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic              ev_valid;
    logic              ev_ready;
    logic [1:0]        ev_ch;
    logic              w_we;
    logic [1:0]        w_addr;
    logic signed [7:0] w_data;
    logic signed [7:0] I_syn;
`ifdef QIF_SYN_SATCNT_EN
    logic [7:0]        sat_cnt;
`endif

    qif_synapse #(
        .N_IN        (N_IN),
        .DEPTH       (DEPTH),
        .DECAY_SHIFT (DSHIFT),
        .W_INIT      (W_INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ch    (ev_ch),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .I_syn    (I_syn)
`ifdef QIF_SYN_SATCNT_EN
        ,
        .sat_cnt  (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit verbose = 1'b1;

    // Behavioural model state
    int mq[$];
    int wt[N_IN];
    int cur;
    int sat_m;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decay(input int c);
        int m;
        if (c == 0) return 0;
        m = (c < 0 ? -c : c) >> DSHIFT;
        if (m == 0) m = 1;
        return (c < 0) ? -m : m;
    endfunction

    task automatic idle();
        tick = 0; ev_valid = 0; ev_ch = '0; w_we = 0; w_addr = '0; w_data = '0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic cyc(input bit t, input bit v, input int ch, input bit we, input int a, input int d);
        bit rdy;
        int w;
        int s;
        tick = t; ev_valid = v; ev_ch = 2'(ch); w_we = we; w_addr = 2'(a); w_data = 8'(d);
        #1;
        rdy = (mq.size() < DEPTH);
        check("ev_ready", int'(ev_ready), int'(rdy));
        w = 0;
        if (t && mq.size() > 0) begin
            w = wt[mq[0]];
            void'(mq.pop_front());
        end
        if (v && rdy) mq.push_back(int'(ev_ch));
        if (we) wt[int'(w_addr)] = int'(w_data);
        if (t) begin
            s = cur - decay(cur) + w;
            if (s > 127 || s < -128) begin
                if (sat_m < 255) sat_m++;
            end
            cur = (s > 127) ? 127 : (s < -128) ? -128 : s;
        end
        @(posedge clk);
        #1;
        check("I_syn", int'(I_syn), cur);
`ifdef QIF_SYN_SATCNT_EN
        check("sat_cnt", int'(sat_cnt), sat_m);
`endif
        if (verbose)
            $display("t=%0t tick=%0d v=%0d ch=%0d we=%0d a=%0d d=%0d -> I_syn=%0d ready=%0d q=%0d",
                     $time, t, v, ch, we, a, d, I_syn, ev_ready, mq.size());
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1;
        #2;
        check("rst_isyn", int'(I_syn), 0);
        check("rst_ready", int'(ev_ready), 1);
`ifdef QIF_SYN_SATCNT_EN
        check("rst_sat", int'(sat_cnt), 0);
`endif
        mq.delete();
        cur = 0;
        sat_m = 0;
        for (int i = 0; i < N_IN; i++) wt[i] = W_INIT;
        @(posedge clk);
        #1;
        rst_n = 0;
        $display("t=%0t reset applied", $time);
    endtask

    task automatic tick_expect(input string tag, input int exp);
        cyc(1, 0, 0, 0, 0, 0);
        check(tag, int'(I_syn), exp);
    endtask

    initial begin
        int seq40 [6] = '{40, 30, 23, 18, 14, 11};
        int seqn40 [3] = '{-40, -30, -23};
        int seq3 [4] = '{2, 1, 0, 0};
        int order [5] = '{10, 28, 51, 79, 80};

        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-stream with queued events and nonzero current
        cyc(0, 0, 0, 1, 0, 55);
        cyc(0, 0, 0, 1, 1, 20);
        cyc(0, 1, 0, 0, 0, 0);
        tick_expect("mid_55", 55);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        do_reset();
        cyc(0, 1, 1, 0, 0, 0);
        tick_expect("post_rst0", 0);
        cyc(0, 1, 0, 0, 0, 0);
        tick_expect("post_rst1", 0);

        // Positive weight with decay
        cyc(0, 0, 0, 1, 0, 40);
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) tick_expect("seq40", seq40[k]);

        // Negative weight, then the minimum-step decay from 3
        do_reset();
        cyc(0, 0, 0, 1, 1, -40);
        cyc(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick_expect("seqn40", seqn40[k]);
        do_reset();
        cyc(0, 0, 0, 1, 0, 3);
        cyc(0, 1, 0, 0, 0, 0);
        tick_expect("start3", 3);
        for (int k = 0; k < 4; k++) tick_expect("seq3", seq3[k]);

        // Positive saturation
        do_reset();
        cyc(0, 0, 0, 1, 2, 100);
        cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        tick_expect("sat_100", 100);
        tick_expect("sat_127", 127);
`ifdef QIF_SYN_SATCNT_EN
        check("sat_cnt_1", int'(sat_cnt), 1);
`endif

        // FIFO full, back-pressure and ordering
        do_reset();
        for (int c = 0; c < 4; c++) cyc(0, 0, 0, 1, c, 10 * (c + 1));
        for (int c = 0; c < 4; c++) cyc(0, 1, c, 0, 0, 0);
        check("full_ready", int'(ev_ready), 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        check("ready_after_pop", int'(ev_ready), 1);
        check("order0", int'(I_syn), order[0]);
        cyc(0, 1, 1, 0, 0, 0);
        for (int k = 1; k < 5; k++) tick_expect("order", order[k]);

        // Same-cycle weight write is not seen by the pop
        do_reset();
        cyc(0, 0, 0, 1, 3, 10);
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0);
        cyc(1, 0, 0, 1, 3, 90);
        check("wr_same_cycle", int'(I_syn), 10);
        tick_expect("wr_next", 98);

        // Randomized traffic
        do_reset();
        verbose = 1'b0;
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            if (n % 100 == 99)
                $display("t=%0t random cycles=%0d I_syn=%0d q=%0d", $time, n + 1, I_syn, mq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qif_synapse.md
# qif_synapse

Synaptic current front-end for the QIF neuron. Accepts weighted spike events from presynaptic sources over a valid/ready handshake and buffers them in a small FIFO. On each integration tick it consumes at most one event, decays the stored current toward zero and adds the event's weight. It drives the signed 8-bit `I_syn` consumed directly by the QIF neuron stage.

## Interface
- `N_IN`, 4: number of presynaptic channels; weight table depth.
- `DEPTH`, 4: event FIFO depth, power of two.
- `DECAY_SHIFT`, 2: decay per tick is |I| >> DECAY_SHIFT.
- `W_INIT`, 0: reset value of every weight, signed 8-bit.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-high (asserted = 1 despite the name).
- `tick`  in  1  integration strobe; state advances only in cycles with `tick` = 1.
- `ev_valid`  in  1  event present.
- `ev_ready`  out  1  FIFO can accept; equals !full.
- `ev_ch`  in  $clog2(N_IN)  channel of event.
- `w_we`  in  1  weight write enable.
- `w_addr`  in  $clog2(N_IN)  weight index.
- `w_data`  in  8  signed weight.
- `I_syn`  out  8  signed synaptic current to neuron.
- `sat_cnt`  out  8  saturation event counter (only with macro, see Configuration).

## Operation
- Push: `ev_valid && ev_ready` writes `ev_ch` to FIFO tail. No push when full, even if a pop occurs the same cycle.
- Pop: in a `tick` cycle with FIFO non-empty, head is popped and w = weight[head]; otherwise w = 0.
- Weight read uses the pre-edge table: a same-cycle write to the popped channel is not seen by that pop.
- Decay d(I): if I = 0, d = 0. Else m = |I| >> DECAY_SHIFT; if m = 0, m = 1. d = sign(I)·m (always moves toward zero, never overshoots).
- Update on tick: s = I − d(I) + w, computed in 10-bit signed; `I_syn` <= clamp(s, −128, 127). Stored state is the clamped value.
- Non-tick cycles: `I_syn` and FIFO read side hold; pushes and weight writes proceed.
- No bypass: an event pushed in a tick cycle into an empty FIFO is not consumed until the next tick.
- Reset: FIFO empty (`ev_ready` = 1), `I_syn` = 0, all weights = W_INIT, `sat_cnt` = 0. Reset mid-operation discards queued events.

## Timing
- `ev_ready` combinational from registered full flag only; no dependency on `ev_valid` or `tick`.
- Event accepted at cycle t; earliest pop at first tick cycle ≥ t+1; `I_syn` reflects it from the following cycle.
- Weight write takes effect for pops in the next cycle onward.
- `I_syn` is a register output: glitch-free, changes only on a tick edge or on reset.

## Configuration
- `QIF_SYN_SATCNT_EN` defined: `sat_cnt` port present; increments (saturating at 255) on each tick where clamping changed s.
- Undefined: `sat_cnt` port and counter absent; all other behaviour identical.

## Structure
- Shared package `qif_pkg`: `I_syn` width (8), internal sum width (10), clamp limits ±127/−128, weight typedef, reset potential constants shared with the neuron.
- Sub-module `qif_evt_fifo` (parametric DEPTH, pointer-plus-wrap-bit full/empty); decay, clamp and weight table stay in top.

## Test plan
- Reset asserted mid-stream with 3 events queued, `I_syn` = 55 -> `I_syn` = 0, `ev_ready` = 1, weights = W_INIT, subsequent ticks produce 0.
- Weight[0] = 40, one ch0 event, ticks every cycle -> `I_syn` sequence 40, 30, 23, 18, 14, 11.
- Weight[1] = −40, one ch1 event -> −40, −30, −23; start from 3 with no events -> 2, 1, 0, 0.
- Weight[2] = 100, two ch2 events, consecutive ticks -> 100, then 127 (175 clamped); `sat_cnt` = 1 with macro.
- No ticks, push 4 events -> `ev_ready` low after 4th, 5th held with `ev_valid` high; one tick -> pop, `ev_ready` high next cycle, 5th accepted, FIFO order preserved.
- Tick pops ch3 while `w_we` writes weight[3] 10→90 same cycle -> adds 10; next ch3 event adds 90.
